// File: rtl/aig_drv_pkg.sv
// rtl/aig_drv_pkg.sv - shared state encoding and MISR step function for aig_vector_driver
package aig_drv_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} drv_state_t;

   // Widest signature the step function handles; callers zero-extend into it.
   localparam int MISR_MAX_W = 32;

   function automatic logic [MISR_MAX_W-1:0] misr_next(
      input logic [MISR_MAX_W-1:0] sig,
      input logic [MISR_MAX_W-1:0] data,
      input logic [MISR_MAX_W-1:0] poly,
      input int                    width
   );
      logic [MISR_MAX_W-1:0] mask;
      logic                  msb;
      mask = {MISR_MAX_W{1'b1}} >> (MISR_MAX_W - width);
      msb  = |(sig & (MISR_MAX_W'(1) << (width - 1)));
      return ((sig << 1) ^ (msb ? poly : '0) ^ data) & mask;
   endfunction

endpackage

// File: rtl/aig_misr.sv
// rtl/aig_misr.sv - signature register compacting circuit responses
module aig_misr
   import aig_drv_pkg::*;
#(
   parameter int                MISR_W    = 16,
   parameter int                DATA_W    = 2,
   parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021,
   parameter logic [MISR_W-1:0] MISR_SEED = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              en,
   input  logic [DATA_W-1:0] data,
   output logic [MISR_W-1:0] sig
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig <= MISR_SEED;
      end else if (clear) begin
         sig <= MISR_SEED;
      end else if (en) begin
         sig <= MISR_W'(misr_next(MISR_MAX_W'(sig), MISR_MAX_W'(data),
                                  MISR_MAX_W'(MISR_POLY), MISR_W));
      end
   end

endmodule

// File: rtl/aig_vector_driver.sv
// rtl/aig_vector_driver.sv - exhaustive input sweep with MISR response compaction
// Optional AIG_DRV_STREAM_EN adds a per-vector {vector, response} stream with back-pressure.
module aig_vector_driver
   import aig_drv_pkg::*;
#(
   parameter int                NUM_IN    = 7,
   parameter int                NUM_OUT   = 2,
   parameter int                SETTLE    = 1,
   parameter int                MISR_W    = 16,
   parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021,
   parameter logic [MISR_W-1:0] MISR_SEED = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic [NUM_IN-1:0]         dut_in,
   input  logic [NUM_OUT-1:0]        dut_out,
`ifdef AIG_DRV_STREAM_EN
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [NUM_IN+NUM_OUT-1:0] resp_data,
`endif
   output logic [MISR_W-1:0]         signature
);

   localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE);
   localparam logic [NUM_IN:0] LAST_VEC    = {1'b0, {NUM_IN{1'b1}}};

   drv_state_t      state;
   logic [NUM_IN:0] vec_cnt;
   logic [7:0]      settle_cnt;
   logic            sample_cycle;
   logic            fire;
   logic            accept;

   assign sample_cycle = (state == RUN) && (settle_cnt == SETTLE_LAST);
   assign accept       = (state == IDLE) && start;

`ifdef AIG_DRV_STREAM_EN
   assign fire       = sample_cycle && resp_ready;
   assign resp_valid = sample_cycle;
   assign resp_data  = {dut_in, dut_out};
`else
   assign fire = sample_cycle;
`endif

   // vec_cnt is cleared on the terminal sample, so dut_in reads 0 outside RUN.
   assign dut_in = vec_cnt[NUM_IN-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         vec_cnt    <= '0;
         settle_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state      <= RUN;
                  busy       <= 1'b1;
                  vec_cnt    <= '0;
                  settle_cnt <= '0;
               end
            end
            RUN: begin
               if (fire) begin
                  settle_cnt <= '0;
                  if (vec_cnt == LAST_VEC) begin
                     state   <= DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     vec_cnt <= '0;
                  end else begin
                     vec_cnt <= vec_cnt + (NUM_IN+1)'(1);
                  end
               end else if (!sample_cycle) begin
                  settle_cnt <= settle_cnt + 8'd1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   aig_misr #(
      .MISR_W    (MISR_W),
      .DATA_W    (NUM_OUT),
      .MISR_POLY (MISR_POLY),
      .MISR_SEED (MISR_SEED)
   ) u_misr (
      .clk   (clk),
      .rst   (rst),
      .clear (accept),
      .en    (fire),
      .data  (dut_out),
      .sig   (signature)
   );

endmodule

// File: tb/tb_aig_vector_driver.sv
// tb/tb_aig_vector_driver.sv - directed self-checking bench for aig_vector_driver
module tb_aig_vector_driver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errs   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // a: 2-in xor circuit, no settle
   logic       a_start = 1'b0, a_busy, a_done;
   logic [1:0] a_in;
   logic       a_out;
   logic [15:0] a_sig;
   assign a_out = a_in[0] ^ a_in[1];

   // b: default 7-in/2-out, settle 3
   logic       b_start = 1'b0, b_busy, b_done, b_mode = 1'b0;
   logic [6:0] b_in;
   logic [1:0] b_out;
   logic [15:0] b_sig;
   assign b_out = b_mode ? {b_in[6] ^ b_in[0], b_in[3]} : 2'b00;

   // c: 1-in, 16 outputs all ones
   logic       c_start = 1'b0, c_busy, c_done;
   logic [0:0] c_in;
   logic [15:0] c_sig;

`ifdef AIG_DRV_STREAM_EN
   logic        a_valid, b_valid, c_valid;
   logic        a_ready = 1'b1;
   logic [2:0]  a_data;
   logic [8:0]  b_data;
   logic [16:0] c_data;
`endif

   aig_vector_driver #(.NUM_IN(2), .NUM_OUT(1), .SETTLE(0)) u_a (
      .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
      .dut_in(a_in), .dut_out(a_out),
`ifdef AIG_DRV_STREAM_EN
      .resp_valid(a_valid), .resp_ready(a_ready), .resp_data(a_data),
`endif
      .signature(a_sig));

   aig_vector_driver #(.SETTLE(3)) u_b (
      .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
      .dut_in(b_in), .dut_out(b_out),
`ifdef AIG_DRV_STREAM_EN
      .resp_valid(b_valid), .resp_ready(1'b1), .resp_data(b_data),
`endif
      .signature(b_sig));

   aig_vector_driver #(.NUM_IN(1), .NUM_OUT(16), .SETTLE(0)) u_c (
      .clk(clk), .rst(rst), .start(c_start), .busy(c_busy), .done(c_done),
      .dut_in(c_in), .dut_out(16'hFFFF),
`ifdef AIG_DRV_STREAM_EN
      .resp_valid(c_valid), .resp_ready(1'b1), .resp_data(c_data),
`endif
      .signature(c_sig));

   function automatic logic [15:0] model_b(input logic mode);
      logic [15:0] s;
      logic [6:0]  v;
      logic [1:0]  o;
      s = 16'h0000;
      for (int i = 0; i < 128; i++) begin
         v = 7'(i);
         o = mode ? {v[6] ^ v[0], v[3]} : 2'b00;
         s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, o};
      end
      return s;
   endfunction

   task automatic run_b(input int pulse_at, output int nbusy, output int ndone, output int step_errs);
      b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      nbusy = 0; ndone = 0; step_errs = 0;
      for (int t = 0; t < 530; t++) begin
         if (b_done) ndone++;
         if (b_busy) begin
            if (int'(b_in) != nbusy / 4) step_errs++;
            nbusy++;
         end
         b_start = (t == pulse_at);
         @(posedge clk); #1;
      end
      b_start = 1'b0;
   endtask

   initial begin
      int nb, nd, se, k;
      logic [15:0] exp1;
      exp1 = model_b(1'b1);

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(a_busy), 32'd0);
      check("rst_done", 32'(a_done), 32'd0);
      check("rst_dut_in", 32'(b_in), 32'd0);
      check("rst_sig", 32'(b_sig), 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 2-in xor sweep
      a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("a_busy", 32'(a_busy), 32'd1);
         check("a_dut_in", 32'(a_in), 32'(i));
         @(posedge clk); #1;
      end
      check("a_done_pulse", 32'(a_done), 32'd1);
      check("a_busy_in_done", 32'(a_busy), 32'd0);
      check("a_dut_in_done", 32'(a_in), 32'd0);
      check("a_sig_final", 32'(a_sig), 32'h0006);
      @(posedge clk); #1;
      check("a_done_clear", 32'(a_done), 32'd0);
      check("a_sig_hold", 32'(a_sig), 32'h0006);

      // default params, outputs tied low
      run_b(-1, nb, nd, se);
      check("b0_busy_cycles", 32'(nb), 32'd512);
      check("b0_done_cycles", 32'(nd), 32'd1);
      check("b0_step", 32'(se), 32'd0);
      check("b0_sig", 32'(b_sig), 32'h0000);

      // non-trivial response, undisturbed then with a stray start at cycle 10
      b_mode = 1'b1;
      run_b(-1, nb, nd, se);
      check("b1_busy_cycles", 32'(nb), 32'd512);
      check("b1_sig", 32'(b_sig), 32'(exp1));
      run_b(10, nb, nd, se);
      check("b2_busy_cycles", 32'(nb), 32'd512);
      check("b2_done_cycles", 32'(nd), 32'd1);
      check("b2_sig", 32'(b_sig), 32'(exp1));

      // reset at vector 37
      b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      k = 0;
      while (b_in != 7'd37 && k < 400) begin
         @(posedge clk); #1;
         k++;
      end
      check("b3_reach_v37", 32'(b_in), 32'd37);
      rst = 1'b1;
      #1;
      check("b3_rst_busy", 32'(b_busy), 32'd0);
      check("b3_rst_dut_in", 32'(b_in), 32'd0);
      check("b3_rst_sig", 32'(b_sig), 32'h0000);
      @(posedge clk); #1;
      rst = 1'b0;
      nd = 0;
      for (int i = 0; i < 5; i++) begin
         if (b_done || b_busy) nd++;
         @(posedge clk); #1;
      end
      check("b3_no_done", 32'(nd), 32'd0);
      run_b(-1, nb, nd, se);
      check("b3_rerun_busy", 32'(nb), 32'd512);
      check("b3_rerun_sig", 32'(b_sig), 32'(exp1));

      // MSB feedback with wide response
      c_start = 1'b1;
      @(posedge clk); #1;
      c_start = 1'b0;
      check("c_dut_in_v0", 32'(c_in), 32'd0);
      @(posedge clk); #1;
      check("c_sig_v0", 32'(c_sig), 32'hFFFF);
      check("c_dut_in_v1", 32'(c_in), 32'd1);
      @(posedge clk); #1;
      check("c_done", 32'(c_done), 32'd1);
      check("c_sig_v1", 32'(c_sig), 32'h1020);

`ifdef AIG_DRV_STREAM_EN
      begin
         int n, stall;
         a_ready = 1'b1;
         a_start = 1'b1;
         @(posedge clk); #1;
         a_start = 1'b0;
         n = 0; stall = 0;
         for (int t = 0; t < 40 && !a_done; t++) begin
            if (a_busy) n++;
            if (a_in == 2'd2 && stall < 5) begin
               a_ready = 1'b0;
               stall++;
               check("s_valid_held", 32'(a_valid), 32'd1);
               check("s_data_stable", 32'(a_data), 32'b101);
            end else begin
               a_ready = 1'b1;
            end
            @(posedge clk); #1;
         end
         a_ready = 1'b1;
         check("s_stall_cycles", 32'(stall), 32'd5);
         check("s_busy_cycles", 32'(n), 32'd9);
         check("s_done", 32'(a_done), 32'd1);
         check("s_sig", 32'(a_sig), 32'h0006);
         check("s_valid_done", 32'(a_valid), 32'd0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
